// File: rtl/seg_counter_pkg.sv
// Shared constants for the two-digit step counter: active-low 7-segment
// codes (bit0 = a .. bit6 = g) and the default prescaler divide.
package seg_counter_pkg;

    localparam int TICK_DIV_DEFAULT = 50_000;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-low 7-segment pattern; codes above 9 blank the digit.
module seg7_decoder
    import seg_counter_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_counter_top.sv
// Board top: two-digit BCD counter advancing by sw20 every TICK_DIV cycles
// while btn0 is held, shown on two active-low 7-segment digits.
module seg_counter_top
    import seg_counter_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       btn1,
    input  logic       btn0,
    input  logic [2:0] sw20,
    output logic [6:0] seg0,
    output logic [6:0] seg1
);

    localparam int            PW      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    logic          sync1_q, sync2_q;
    logic          run, tick, carry;
    logic [PW-1:0] pre_q, pre_d;
    logic [3:0]    ones_q, ones_d, tens_q, tens_d;
    logic [4:0]    osum, tsum;

    always_comb begin
        run   = ~sync2_q;
        tick  = run && (pre_q == PRE_MAX);
        pre_d = pre_q;
        if (run) pre_d = tick ? '0 : pre_q + 1'b1;

        // 5-bit sums so the decimal carry is visible before folding back to 0-9
        osum   = {1'b0, ones_q} + {2'b00, sw20};
        carry  = (osum >= 5'd10);
        tsum   = {1'b0, tens_q} + {4'b0000, carry};
        ones_d = ones_q;
        tens_d = tens_q;
        if (tick) begin
            ones_d = carry ? 4'(osum - 5'd10) : osum[3:0];
            tens_d = (tsum >= 5'd10) ? 4'd0 : tsum[3:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!btn1) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            pre_q   <= '0;
            ones_q  <= 4'd0;
            tens_q  <= 4'd0;
        end else begin
            sync1_q <= btn0;
            sync2_q <= sync1_q;
            pre_q   <= pre_d;
            ones_q  <= ones_d;
            tens_q  <= tens_d;
        end
    end

    seg7_decoder u_dec_ones (.bcd_i(ones_q), .seg_o(seg0));
    seg7_decoder u_dec_tens (.bcd_i(tens_q), .seg_o(seg1));

endmodule

// File: tb/tb_seg_counter_top.sv
// Directed bench for seg_counter_top with TICK_DIV = 4: reset, step runs,
// carry/wrap, zero step, pause/resume and mid-run reset.
module tb_seg_counter_top;

    logic       clk = 1'b0;
    logic       btn1, btn0;
    logic [2:0] sw20;
    logic [6:0] seg0, seg1;
    int         errs = 0;
    int         nchk = 0;
    int         v;

    localparam logic [6:0] SEGT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                         7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    always #5 clk = ~clk;

    seg_counter_top #(.TICK_DIV(4)) dut (
        .clk (clk),
        .btn1(btn1),
        .btn0(btn0),
        .sw20(sw20),
        .seg0(seg0),
        .seg1(seg1)
    );

    function automatic logic [13:0] dv(input int val);
        return {SEGT[val / 10], SEGT[val % 10]};
    endfunction

    task automatic chk(input string tag, input logic [13:0] act, input logic [13:0] exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got seg1/seg0=%h/%h want %h/%h",
                     tag, act[13:7], act[6:0], exp[13:7], exp[6:0]);
        end
    endtask

    task automatic tk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        btn1 = 1'b0; btn0 = 1'b1; sw20 = 3'd0;
        tk(1);
        chk("rst_first_edge", {seg1, seg0}, dv(0));
        tk(1);
        chk("rst", {seg1, seg0}, dv(0));
        btn1 = 1'b1;
        tk(50);
        chk("idle_50", {seg1, seg0}, dv(0));

        // step 5: first change 2 + 4 edges after press, then every 4
        sw20 = 3'd5; btn0 = 1'b0;
        tk(5);
        chk("s5_lat", {seg1, seg0}, dv(0));
        tk(1);
        v = 5;
        chk("s5_first", {seg1, seg0}, dv(5));
        for (int k = 2; k <= 20; k++) begin
            tk(4);
            v = (v + 5) % 100;
            chk("s5_run", {seg1, seg0}, dv(v));
            if (v == 15) chk("s5_15", {seg1, seg0}, {7'h79, 7'h12});
        end
        chk("s5_wrap", {seg1, seg0}, {7'h40, 7'h40});

        sw20 = 3'd7;
        for (int k = 1; k <= 15; k++) begin
            tk(4);
            v = (v + 7) % 100;
            chk("s7_run", {seg1, seg0}, dv(v));
        end
        chk("s7_wrap05", {seg1, seg0}, {7'h40, 7'h12});

        btn0 = 1'b1; btn1 = 1'b0;
        tk(1);
        btn1 = 1'b1; sw20 = 3'd0; btn0 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tk(20);
            chk("s0_hold", {seg1, seg0}, dv(0));
        end

        // pause: release one cycle after 10 shows, resume at frozen prescaler phase
        btn0 = 1'b1; btn1 = 1'b0;
        tk(1);
        btn1 = 1'b1; sw20 = 3'd5; btn0 = 1'b0;
        tk(6);
        chk("p_05", {seg1, seg0}, dv(5));
        tk(4);
        chk("p_10", {seg1, seg0}, dv(10));
        tk(1);
        btn0 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tk(10);
            chk("p_frozen", {seg1, seg0}, dv(10));
        end
        btn0 = 1'b0;
        tk(2);
        chk("p_resume_pre", {seg1, seg0}, dv(10));
        tk(1);
        chk("p_resume_15", {seg1, seg0}, dv(15));
        v = 15;
        for (int k = 0; k < 4; k++) begin
            tk(4);
            v = v + 5;
            chk("m_run", {seg1, seg0}, dv(v));
        end

        btn1 = 1'b0;
        #2;
        chk("m_no_edge", {seg1, seg0}, dv(35));
        @(posedge clk); #1;
        chk("m_rst", {seg1, seg0}, {7'h40, 7'h40});
        btn1 = 1'b1;
        tk(5);
        chk("m_restart_lat", {seg1, seg0}, dv(0));
        tk(1);
        chk("m_restart_05", {seg1, seg0}, dv(5));

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
